// File: rtl/control_logic_if.sv
// Purpose: bundles the fetch/register-file inputs and the registered decode outputs of control_logic.
// Ports: inst, pc, rd1, rd2 flow from the fetch/regfile side into the control unit; reg_dest, out, next_pc,
//        mem_write, mem_to_reg and reg_write flow back out. master = stimulus/pipeline side, slave = control unit.
interface control_logic_if;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        reg_dest;
    logic [31:0] out;
    logic [31:0] next_pc;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;

    modport master (
        output inst, pc, rd1, rd2,
        input  reg_dest, out, next_pc, mem_write, mem_to_reg, reg_write
    );

    modport slave (
        input  inst, pc, rd1, rd2,
        output reg_dest, out, next_pc, mem_write, mem_to_reg, reg_write
    );
endinterface

// File: rtl/control_logic.sv
// Purpose: MIPS-subset control unit with integrated ALU and next-PC logic (optional shifts via CTRL_SHIFT_EN).
// Latency: 1 cycle; every output is a register loaded from the combinational decode of the current inputs.
// Backpressure: none; a new instruction is accepted every cycle. Ports: clk, rst_n, bus (control_logic_if.slave).
module control_logic #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_logic_if.slave       bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;
    logic [31:0] pc4;
    logic [31:0] br_target;

    logic        reg_dest_d, reg_dest_q;
    logic [31:0] out_d, out_q;
    logic [31:0] next_pc_d, next_pc_q;
    logic        mem_write_d, mem_write_q;
    logic        mem_to_reg_d, mem_to_reg_q;
    logic        reg_write_d, reg_write_q;

    assign opcode    = bus.inst[31:26];
    assign funct     = bus.inst[5:0];
    assign imm_sx    = {{16{bus.inst[15]}}, bus.inst[15:0]};
    assign imm_zx    = {16'h0000, bus.inst[15:0]};
    assign pc4       = bus.pc + 32'd4;
    assign br_target = pc4 + {imm_sx[29:0], 2'b00};

    // Defaults describe the "unsupported" outcome; each legal encoding overrides only what it needs.
    always_comb begin
        reg_dest_d   = 1'b0;
        out_d        = 32'h0;
        next_pc_d    = pc4;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                reg_dest_d  = 1'b1;
                reg_write_d = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: out_d = bus.rd1 + bus.rd2;
                    FN_SUB, FN_SUBU: out_d = bus.rd1 - bus.rd2;
                    FN_AND:          out_d = bus.rd1 & bus.rd2;
                    FN_OR:           out_d = bus.rd1 | bus.rd2;
                    FN_XOR:          out_d = bus.rd1 ^ bus.rd2;
                    FN_NOR:          out_d = ~(bus.rd1 | bus.rd2);
                    FN_SLT:          out_d = {31'h0, $signed(bus.rd1) < $signed(bus.rd2)};
                    FN_SLTU:         out_d = {31'h0, bus.rd1 < bus.rd2};
                    FN_JR: begin
                        reg_write_d = 1'b0;
                        next_pc_d   = bus.rd1;
                    end
`ifdef CTRL_SHIFT_EN
                    FN_SLL:          out_d = bus.rd2 << bus.inst[10:6];
                    FN_SRL:          out_d = bus.rd2 >> bus.inst[10:6];
                    FN_SRA:          out_d = $signed(bus.rd2) >>> bus.inst[10:6];
`endif
                    default: begin
                        reg_dest_d  = 1'b0;
                        reg_write_d = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                reg_write_d = 1'b1;
                out_d       = bus.rd1 + imm_sx;
            end
            OP_SLTI: begin
                reg_write_d = 1'b1;
                out_d       = {31'h0, $signed(bus.rd1) < $signed(imm_sx)};
            end
            OP_ANDI: begin
                reg_write_d = 1'b1;
                out_d       = bus.rd1 & imm_zx;
            end
            OP_ORI: begin
                reg_write_d = 1'b1;
                out_d       = bus.rd1 | imm_zx;
            end
            OP_XORI: begin
                reg_write_d = 1'b1;
                out_d       = bus.rd1 ^ imm_zx;
            end
            OP_LUI: begin
                reg_write_d = 1'b1;
                out_d       = {bus.inst[15:0], 16'h0000};
            end
            OP_LW: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                out_d        = bus.rd1 + imm_sx;
            end
            OP_SW: begin
                mem_write_d = 1'b1;
                out_d       = bus.rd1 + imm_sx;
            end
            OP_BEQ, OP_BNE: begin
                out_d = bus.rd1 - bus.rd2;
                // opcode[0] distinguishes bne from beq.
                if ((bus.rd1 == bus.rd2) != opcode[0]) begin
                    next_pc_d = br_target;
                end
            end
            OP_J: begin
                next_pc_d = {pc4[31:28], bus.inst[25:0], 2'b00};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_dest_q   <= 1'b0;
            out_q        <= 32'h0;
            next_pc_q    <= RESET_PC;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            reg_dest_q   <= reg_dest_d;
            out_q        <= out_d;
            next_pc_q    <= next_pc_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign bus.reg_dest   = reg_dest_q;
    assign bus.out        = out_q;
    assign bus.next_pc    = next_pc_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_to_reg = mem_to_reg_q;
    assign bus.reg_write  = reg_write_q;

endmodule

// File: tb/tb_control_logic.sv
// Purpose: self-checking bench for control_logic; expected outputs are queued when a vector is driven
// and popped when the registered result appears one edge later.
// Covers reset values, every decoded class, branch taken/not-taken, PC wrap and asynchronous mid-run reset.
module tb_control_logic;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic        full;     // 0: only next_pc / strobes are defined for this vector
        logic        rdst;
        logic [31:0] res;
        logic [31:0] npc;
        logic        mw;
        logic        m2r;
        logic        rw;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    control_logic_if bus ();

    control_logic #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ex(input logic rdst, input logic [31:0] res, input logic [31:0] npc,
                                input logic mw, input logic m2r, input logic rw);
        ex = '{full: 1'b1, rdst: rdst, res: res, npc: npc, mw: mw, m2r: m2r, rw: rw};
    endfunction

    function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] sh);
        rt = {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
        it = {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".next_pc"},    bus.next_pc,    e.npc);
            chk({tag, ".reg_write"},  {31'h0, bus.reg_write},  {31'h0, e.rw});
            chk({tag, ".mem_write"},  {31'h0, bus.mem_write},  {31'h0, e.mw});
            chk({tag, ".mem_to_reg"}, {31'h0, bus.mem_to_reg}, {31'h0, e.m2r});
            if (e.full) begin
                chk({tag, ".out"},      bus.out,                 e.res);
                chk({tag, ".reg_dest"}, {31'h0, bus.reg_dest},   {31'h0, e.rdst});
            end
        end
    endtask

    task automatic run(input string tag, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input exp_t e);
        @(negedge clk);
        bus.inst = i;
        bus.pc   = p;
        bus.rd1  = a;
        bus.rd2  = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        exp_t e;
        logic [31:0] a, b;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.inst = 32'h00229821;
        bus.pc   = 32'd4;
        bus.rd1  = 32'd5;
        bus.rd2  = 32'd2;

        // Reset state, with clock edges passing while reset is held.
        #13;
        sb.push_back(ex(1'b0, 32'h0, RST_PC, 1'b0, 1'b0, 1'b0));
        compare("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run("addu",   32'h00229821, 32'd4,  32'd5, 32'd2, ex(1, 32'd7, 32'd8, 0, 0, 1));
        run("addi",   32'h20229821, 32'd12, 32'd5, 32'd2, ex(0, 32'hFFFF9826, 32'd16, 0, 0, 1));
        run("beq_nt", 32'h10229821, 32'd13, 32'd5, 32'd2, ex(0, 32'd3, 32'd17, 0, 0, 0));
        run("beq_t",  32'h10229821, 32'd13, 32'd5, 32'd5, ex(0, 32'd0, 32'd17 + 32'hFFFE6084, 0, 0, 0));
        run("lw",     32'h8C229821, 32'd14, 32'd7, 32'd2, ex(0, 32'hFFFF9828, 32'd18, 0, 1, 1));
        run("sw",     32'hAC229821, 32'd20, 32'd5, 32'd1, ex(0, 32'hFFFF9826, 32'd24, 1, 0, 0));
        run("add_wrap", rt(6'h20, 0), 32'd40, 32'hFFFF_FFFF, 32'd2, ex(1, 32'd1, 32'd44, 0, 0, 1));
        run("sub",    rt(6'h22, 0), 32'd40, 32'd5, 32'd7, ex(1, 32'hFFFF_FFFE, 32'd44, 0, 0, 1));
        run("and",    rt(6'h24, 0), 32'd40, 32'hF0F0_1234, 32'hFF00_FF00, ex(1, 32'hF000_1200, 32'd44, 0, 0, 1));
        run("or",     rt(6'h25, 0), 32'd40, 32'hF0F0_1234, 32'hFF00_FF00, ex(1, 32'hFFF0_FF34, 32'd44, 0, 0, 1));
        run("xor",    rt(6'h26, 0), 32'd40, 32'hF0F0_1234, 32'hFF00_FF00, ex(1, 32'h0FF0_ED34, 32'd44, 0, 0, 1));
        run("nor",    rt(6'h27, 0), 32'd40, 32'hF0F0_1234, 32'hFF00_FF00, ex(1, 32'h000F_00CB, 32'd44, 0, 0, 1));
        run("slt",    rt(6'h2A, 0), 32'd40, 32'hFFFF_FFFF, 32'd1, ex(1, 32'd1, 32'd44, 0, 0, 1));
        run("sltu",   rt(6'h2B, 0), 32'd40, 32'hFFFF_FFFF, 32'd1, ex(1, 32'd0, 32'd44, 0, 0, 1));
        e = ex(0, 32'd0, 32'h0000_4000, 0, 0, 0);
        e.full = 1'b0;
        run("jr",     rt(6'h08, 0), 32'd40, 32'h0000_4000, 32'd1, e);
        run("slti_t", it(6'h0A, 16'h0005), 32'd60, 32'hFFFF_FFFE, 32'd0, ex(0, 32'd1, 32'd64, 0, 0, 1));
        run("slti_f", it(6'h0A, 16'h8000), 32'd60, 32'd0, 32'd0, ex(0, 32'd0, 32'd64, 0, 0, 1));
        run("andi",   it(6'h0C, 16'h8F0F), 32'd60, 32'hFFFF_1234, 32'd0, ex(0, 32'h0000_0204, 32'd64, 0, 0, 1));
        run("ori",    it(6'h0D, 16'h8F0F), 32'd60, 32'hFFFF_1234, 32'd0, ex(0, 32'hFFFF_9F3F, 32'd64, 0, 0, 1));
        run("xori",   it(6'h0E, 16'h8F0F), 32'd60, 32'hFFFF_1234, 32'd0, ex(0, 32'hFFFF_9D3B, 32'd64, 0, 0, 1));
        run("bne_t",  it(6'h05, 16'h0003), 32'd100, 32'd1, 32'd2, ex(0, 32'hFFFF_FFFF, 32'd116, 0, 0, 0));
        run("bne_nt", it(6'h05, 16'h0003), 32'd100, 32'd3, 32'd3, ex(0, 32'd0, 32'd104, 0, 0, 0));
        run("bad_op", it(6'h3F, 16'h1234), 32'hFFFF_FFFC, 32'd9, 32'd9, ex(0, 32'd0, 32'd0, 0, 0, 0));
        run("bad_fn", rt(6'h3F, 0), 32'd80, 32'd9, 32'd9, ex(0, 32'd0, 32'd84, 0, 0, 0));
`ifdef CTRL_SHIFT_EN
        run("sll", rt(6'h00, 5'd4), 32'd80, 32'd0, 32'h8000_0001, ex(1, 32'h0000_0010, 32'd84, 0, 0, 1));
        run("srl", rt(6'h02, 5'd4), 32'd80, 32'd0, 32'h8000_0001, ex(1, 32'h0800_0000, 32'd84, 0, 0, 1));
        run("sra", rt(6'h03, 5'd4), 32'd80, 32'd0, 32'h8000_0001, ex(1, 32'hF800_0000, 32'd84, 0, 0, 1));
`else
        run("sll", rt(6'h00, 5'd4), 32'd80, 32'd0, 32'h8000_0001, ex(0, 32'd0, 32'd84, 0, 0, 0));
        run("srl", rt(6'h02, 5'd4), 32'd80, 32'd0, 32'h8000_0001, ex(0, 32'd0, 32'd84, 0, 0, 0));
        run("sra", rt(6'h03, 5'd4), 32'd80, 32'd0, 32'h8000_0001, ex(0, 32'd0, 32'd84, 0, 0, 0));
`endif

        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            b = $urandom;
            run("addu_rand", rt(6'h21, 0), 32'd200, a, b, ex(1, a + b, 32'd204, 0, 0, 1));
        end

        run("j", 32'h08229821, 32'd13, 32'd5, 32'd2, ex(0, 32'd0, 32'h008A_6084, 0, 0, 0));

        // Asynchronous reset between edges must clear outputs without waiting for a clock.
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(ex(1'b0, 32'h0, RST_PC, 1'b0, 1'b0, 1'b0));
        compare("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run("lui_after_rst", it(6'h0F, 16'hABCD), 32'd300, 32'd0, 32'd0, ex(0, 32'hABCD_0000, 32'd304, 0, 0, 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
